// File: rtl/core_hazard_mc.sv
// Hazard/stall unit: load-use detection plus N_CH address-decoded peripheral channels.
// Optional bus-error timeout enabled with `define CORE_HAZARD_TIMEOUT_EN.
module core_hazard_mc #(
  parameter int N_CH = 2,
  parameter logic [N_CH*64-1:0] PERIPH_BASE =
    {64'h2000_1000, 64'h2000_0000},
  parameter logic [N_CH*64-1:0] PERIPH_MASK =
    {64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_F000},
  parameter int TIMEOUT_CYCLES = 256,
  localparam int SW = $clog2(N_CH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      IF_rs,
  input  logic [4:0]      IF_rt,
  input  logic            IF_B_is_reg,
  input  logic [4:0]      ID_W_regnum,
  input  logic            ID_mem_read,
  input  logic [63:0]     addr,
  input  logic            EX_mem_read,
  input  logic            EX_mem_write,
  input  logic [N_CH-1:0] d_ready,
  output logic [N_CH-1:0] d_valid,
  output logic [SW-1:0]   d_sel,
  output logic            busy,
  output logic            bus_err,
  output logic            stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [N_CH-1:0] d_valid_q, d_valid_d;
  logic [SW-1:0]   d_sel_q, d_sel_d;
  logic [N_CH-1:0] hit;
  logic [SW-1:0]   hit_idx;
  logic            any_hit;
  logic            ready_sel;
  logic            load_use;
  logic            tmo;

  assign load_use = ID_mem_read && (ID_W_regnum != 5'd0) &&
    ((IF_rs == ID_W_regnum) ||
     (IF_B_is_reg && (IF_rt == ID_W_regnum)));

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit[i] = (EX_mem_read || EX_mem_write) &&
        ((addr & PERIPH_MASK[64*i +: 64]) == PERIPH_BASE[64*i +: 64]);
    end
  end

  // Scan downward so the lowest matching window wins.
  always_comb begin
    hit_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = SW'(i);
    end
  end

  assign any_hit = |hit;

  // d_valid is one-hot on d_sel while requesting, so this picks d_ready[d_sel].
  assign ready_sel = |(d_ready & d_valid_q);

`ifdef CORE_HAZARD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q;

  assign tmo = (state_q == S_REQ) && !ready_sel &&
    (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && any_hit) cnt_d = '0;
    else if (state_q == S_REQ) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= tmo;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES < 2);
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      d_valid_q <= '0;
      d_sel_q   <= '0;
    end else begin
      state_q   <= state_d;
      d_valid_q <= d_valid_d;
      d_sel_q   <= d_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (any_hit) state_d = S_REQ;
      S_REQ:  if (ready_sel || tmo) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    d_valid_d = d_valid_q;
    d_sel_d   = d_sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_hit) begin
          d_sel_d = hit_idx;
          for (int i = 0; i < N_CH; i++) begin
            d_valid_d[i] = (hit_idx == SW'(i));
          end
        end
      end
      S_REQ:  if (ready_sel || tmo) d_valid_d = '0;
      S_DONE: d_valid_d = '0;
      default: d_valid_d = '0;
    endcase
  end

  assign d_valid = d_valid_q;
  assign d_sel   = d_sel_q;
  assign busy    = (state_q != S_IDLE);
  assign stall   = load_use ||
    ((state_q == S_IDLE) && any_hit) ||
    (state_q == S_REQ);

endmodule
